// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding and default sizing for the bus arbiter
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, GRANT = 2'b01, TURN = 2'b10} arb_state_e;
  localparam int NUM_REQ_DEF = 3;
  localparam int HOLD_MAX_DEF = 16;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting at ptr, wrapping modulo NUM_REQ
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [1:0]         index
);
  function automatic logic [1:0] wrap(input int v);
    return 2'(v % NUM_REQ);
  endfunction
  // walk from the farthest offset back to ptr so the nearest requester is written last
  always_comb begin
    win = '0;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[wrap(int'(ptr) + k)]) begin
        win = '0;
        win[wrap(int'(ptr) + k)] = 1'b1;
        index = wrap(int'(ptr) + k);
      end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of a shared tri-state bus with a turnaround cycle between tenures.
// Define BUS_ARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic               clk,
  input  logic               low_clr,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rel,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         owner,
  output logic               busy,
  output logic               cpu_stall,
  output logic               timeout
);
  localparam logic [1:0] LAST = 2'(NUM_REQ - 1);
  if (NUM_REQ < 2 || NUM_REQ > 4 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_param
    $error("bus_arbiter: parameter out of range");
  end
  arb_state_e         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt, w_win;
  logic [1:0]         r_owner, w_owner_nxt, r_ptr, w_ptr_nxt, w_idx;
  logic               r_arm, r_timeout, w_done, w_force;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .win   (w_win),
    .index (w_idx)
  );
  assign w_done = rel[r_owner] | ~req[r_owner];
`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge low_clr)
    if (!low_clr) r_cnt <= '0;
    else r_cnt <= (r_state == GRANT) ? r_cnt + 8'd1 : '0;
  assign w_force = (r_state == GRANT) && (r_cnt == 8'(HOLD_MAX - 1)) && !w_done;
`else
  assign w_force = 1'b0;
`endif
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE:
        if (r_arm && |req) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_win;
          w_owner_nxt = w_idx;
          w_ptr_nxt   = (w_idx == LAST) ? 2'd0 : w_idx + 2'd1;
        end
      GRANT:
        if (w_done || w_force) begin
          w_state_nxt = TURN;
          w_gnt_nxt   = '0;
        end
      default: w_state_nxt = IDLE;
    endcase
  end
  // r_arm holds off granting on the first edge after reset release
  always_ff @(posedge clk or negedge low_clr)
    if (!low_clr) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_arm     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_arm     <= 1'b1;
      r_timeout <= w_force;
    end
  assign gnt       = r_gnt;
  assign owner     = r_owner;
  assign busy      = (r_state == GRANT);
  assign timeout   = r_timeout;
  assign cpu_stall = req[0] & ~r_gnt[0];
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table plus hand sequences, expected outputs queued and popped after each edge
module tb_bus_arbiter;
  typedef struct {
    logic       lc;
    logic [2:0] req;
    logic [2:0] rel;
    logic [2:0] gnt;
    logic       busy;
    logic [1:0] own;
    logic       to;
  } vec_t;
  logic       clk = 1'b0;
  logic       low_clr = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] rel = '0;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       busy, cpu_stall, timeout;
  int         checks = 0;
  int         failures = 0;
  vec_t       sb[$];
  vec_t       tbl[26];
  bus_arbiter #(.NUM_REQ(3), .HOLD_MAX(4)) dut (
    .clk       (clk),
    .low_clr   (low_clr),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .cpu_stall (cpu_stall),
    .timeout   (timeout)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(gnt)) begin
      failures++;
      $display("FAIL onehot gnt=%b", gnt);
    end
  end
  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask
  task automatic step(input vec_t v);
    vec_t e;
    low_clr = v.lc;
    req = v.req;
    rel = v.rel;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gnt", gnt, e.gnt);
    chk("busy", {2'b0, busy}, {2'b0, e.busy});
    chk("owner", {1'b0, owner}, {1'b0, e.own});
    chk("timeout", {2'b0, timeout}, {2'b0, e.to});
    chk("cpu_stall", {2'b0, cpu_stall}, {2'b0, e.req[0] & ~e.gnt[0]});
  endtask
  initial begin
    tbl = '{
      '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0},
      '{1'b1, 3'b010, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0},
      '{1'b1, 3'b010, 3'b000, 3'b010, 1'b1, 2'd1, 1'b0},
      '{1'b1, 3'b010, 3'b000, 3'b010, 1'b1, 2'd1, 1'b0},
      '{1'b1, 3'b010, 3'b010, 3'b000, 1'b0, 2'd1, 1'b0},
      '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0},
      '{1'b1, 3'b111, 3'b000, 3'b100, 1'b1, 2'd2, 1'b0},
      '{1'b1, 3'b111, 3'b000, 3'b100, 1'b1, 2'd2, 1'b0},
      '{1'b1, 3'b111, 3'b100, 3'b000, 1'b0, 2'd2, 1'b0},
      '{1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 2'd2, 1'b0},
      '{1'b1, 3'b111, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0},
      '{1'b1, 3'b111, 3'b100, 3'b001, 1'b1, 2'd0, 1'b0},
      '{1'b1, 3'b111, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0},
      '{1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0},
      '{1'b1, 3'b111, 3'b000, 3'b010, 1'b1, 2'd1, 1'b0},
      '{1'b1, 3'b111, 3'b010, 3'b000, 1'b0, 2'd1, 1'b0},
      '{1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0},
      '{1'b1, 3'b111, 3'b000, 3'b100, 1'b1, 2'd2, 1'b0},
      '{1'b1, 3'b011, 3'b000, 3'b000, 1'b0, 2'd2, 1'b0},
      '{1'b1, 3'b011, 3'b000, 3'b000, 1'b0, 2'd2, 1'b0},
      '{1'b1, 3'b011, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0},
      '{1'b1, 3'b011, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0},
      '{1'b1, 3'b011, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0},
      '{1'b1, 3'b011, 3'b000, 3'b010, 1'b1, 2'd1, 1'b0},
      '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0},
      '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0}
    };
    for (int i = 0; i < 26; i++) step(tbl[i]);
    step('{1'b1, 3'b010, 3'b000, 3'b010, 1'b1, 2'd1, 1'b0});
    #2 low_clr = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 3'b000);
    chk("async_rst_busy", {2'b0, busy}, 3'b000);
    chk("async_rst_owner", {1'b0, owner}, 3'b000);
    step('{1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0});
    step('{1'b1, 3'b110, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0});
    step('{1'b1, 3'b110, 3'b000, 3'b010, 1'b1, 2'd1, 1'b0});
    step('{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0});
    step('{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0});
    step('{1'b1, 3'b001, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0});
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) step('{1'b1, 3'b001, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0});
    step('{1'b1, 3'b011, 3'b000, 3'b000, 1'b0, 2'd0, 1'b1});
    step('{1'b1, 3'b011, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0});
    step('{1'b1, 3'b011, 3'b000, 3'b010, 1'b1, 2'd1, 1'b0});
    step('{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0});
`else
    for (int i = 0; i < 100; i++) step('{1'b1, 3'b001, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0});
    step('{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0});
`endif
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard left=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
